// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// The master drives operands and out_ready; the slave (adder) drives results and in_ready.
interface pipelined_adder_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, in1, in2, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, in1, in2, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract split into STAGES carry-chained slices, one slice per clock.
// Operands ride forward with their operation; the last stage holds the full sum and flags.
module pipelined_adder #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input logic           clk,
  input logic           rst,
  pipelined_adder_if.slave bus
);
  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  logic             vld   [STAGES];
  logic             vld_d [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic [WIDTH-1:0] s_d   [STAGES];
  logic             c_q   [STAGES];
  logic             c_d   [STAGES];
  logic             advance;

  // The whole pipe moves as one; a stalled head freezes every stage, bubbles included.
  assign advance = !vld[LAST] || bus.out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CW:0] slice;

    if (k == 0) begin : g_head
      logic [WIDTH-1:0] b_eff;
      assign b_eff    = bus.sub ? ~bus.in2 : bus.in2;
      assign slice    = {1'b0, bus.in1[CW-1:0]} + {1'b0, b_eff[CW-1:0]}
                      + (CW+1)'(bus.sub | bus.cin);
      assign vld_d[k] = bus.in_valid;
      assign a_d[k]   = bus.in1;
      assign b_d[k]   = b_eff;
      assign s_d[k]   = WIDTH'(slice[CW-1:0]);
    end else begin : g_body
      assign slice    = {1'b0, a_q[k-1][k*CW +: CW]} + {1'b0, b_q[k-1][k*CW +: CW]}
                      + (CW+1)'(c_q[k-1]);
      assign vld_d[k] = vld[k-1];
      assign a_d[k]   = a_q[k-1];
      assign b_d[k]   = b_q[k-1];
      // Upper sum bits are still zero here, so OR-ing in the new slice is a plain insert.
      assign s_d[k]   = s_q[k-1] | (WIDTH'(slice[CW-1:0]) << (k*CW));
    end

    assign c_d[k] = slice[CW];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        vld[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
    end else if (advance) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        vld[k] <= vld_d[k];
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
      end
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = vld[LAST];
  assign bus.sum       = s_q[LAST];
  assign bus.cout      = c_q[LAST];
  assign bus.ovf       = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1])
                      && (s_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);
endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed literals, streaming and backpressure on a 64/4 instance,
// plus boundary-operand sweeps on other WIDTH/STAGES shapes.
module tb_pipelined_adder;
  localparam int WIDTH  = 64;
  localparam int STAGES = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_sw = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   sweep_done = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_adder_if #(.WIDTH(WIDTH)) bus ();
  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) u_dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arithmetic on w-bit operands: unsigned result/carry plus true signed range test.
  function automatic void ref_op(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                                 input logic ci, input logic sb, output logic [63:0] s,
                                 output logic co, output logic ov);
    logic [63:0] mask, a, b;
    logic [64:0] u;
    logic signed [65:0] sa, sbv, t, lim;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    a = a_in & mask;
    b = b_in & mask;
    u = sb ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b} + {64'd0, ci});
    s = u[63:0] & mask;
    co = sb ? (a >= b) : u[w];
    lim = 66'sd1 <<< (w - 1);
    sa = $signed({2'b00, a});
    if (a[w-1]) sa = sa - (lim <<< 1);
    sbv = $signed({2'b00, b});
    if (b[w-1]) sbv = sbv - (lim <<< 1);
    t = sb ? (sa - sbv) : (sa + sbv + $signed({65'd0, ci}));
    ov = (t >= lim) || (t < -lim);
  endfunction

  typedef struct {
    logic [63:0] s;
    logic        c;
    logic        o;
    int          due;
  } exp_t;
  exp_t q[$];

  logic        was_rst = 1'b0;
  logic        hold = 1'b0;
  logic [63:0] hs;
  logic        hc, ho;

  // Model: each accepted op needs STAGES-1 further advancing edges before it is visible.
  always @(negedge clk) begin : p_cmp
    logic mv, adv, ec, eo;
    logic [63:0] es;
    if (was_rst) begin
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_sum", bus.sum, 64'd0);
      chk("rst_cout", 64'(bus.cout), 64'd0);
      chk("rst_ovf", 64'(bus.ovf), 64'd0);
    end
    if (rst) begin
      q.delete();
    end else begin
      mv = (q.size() > 0) && (q[0].due == 0);
      chk("out_valid", 64'(bus.out_valid), 64'(mv));
      chk("in_ready", 64'(bus.in_ready), 64'(!bus.out_valid || bus.out_ready));
      if (hold) begin
        chk("hold_sum", bus.sum, hs);
        chk("hold_cout", 64'(bus.cout), 64'(hc));
        chk("hold_ovf", 64'(bus.ovf), 64'(ho));
      end
      if (mv && bus.out_valid) begin
        chk("sum", bus.sum, q[0].s);
        chk("cout", 64'(bus.cout), 64'(q[0].c));
        chk("ovf", 64'(bus.ovf), 64'(q[0].o));
      end
      adv = !mv || bus.out_ready;
      if (mv && bus.out_ready) void'(q.pop_front());
      if (adv) foreach (q[i]) if (q[i].due > 0) q[i].due--;
      if (bus.in_valid && adv) begin
        ref_op(WIDTH, bus.in1, bus.in2, bus.cin, bus.sub, es, ec, eo);
        q.push_back('{s: es, c: ec, o: eo, due: STAGES - 1});
      end
    end
    hold = !rst && bus.out_valid && !bus.out_ready;
    hs = bus.sum;
    hc = bus.cout;
    ho = bus.ovf;
    was_rst = rst;
  end

  task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] b,
                       input logic c, input logic s, input logic r);
    bus.in_valid = v;
    bus.in1 = a;
    bus.in2 = b;
    bus.cin = c;
    bus.sub = s;
    bus.out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic run_directed(input string name, input logic [63:0] a, input logic [63:0] b,
                              input logic c, input logic s, input logic [63:0] es,
                              input logic ec, input logic eo);
    drive(1'b1, a, b, c, s, 1'b1);
    for (int unsigned k = 1; k < STAGES; k++) begin
      chk({name, "_early"}, 64'(bus.out_valid), 64'd0);
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    end
    chk({name, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({name, "_sum"}, bus.sum, es);
    chk({name, "_cout"}, 64'(bus.cout), 64'(ec));
    chk({name, "_ovf"}, 64'(bus.ovf), 64'(eo));
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  function automatic logic [63:0] pick_op();
    case ($urandom_range(3))
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'h8000_0000_0000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin : p_main
    logic [63:0] ms;
    logic mc, mo;
    int issued, guard;
    bus.in_valid = 1'b0;
    bus.in1 = '0;
    bus.in2 = '0;
    bus.cin = 1'b0;
    bus.sub = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    rst_sw = 1'b0;

    ref_op(64, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, ms, mc, mo);
    chk("model_carry", {ms[61:0], mc, mo}, 64'h2);
    ref_op(64, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, ms, mc, mo);
    chk("model_sub_sum", ms, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("model_sub_flags", 64'({mc, mo}), 64'd3);
    ref_op(64, 64'd3, 64'd5, 1'b0, 1'b1, ms, mc, mo);
    chk("model_borrow", {ms[61:0], mc, mo}, 64'hFFFF_FFFF_FFFF_FFF8);

    run_directed("carry", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
    run_directed("subovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
                 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    run_directed("borrow", 64'd3, 64'd5, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);

    for (int unsigned i = 0; i < 100; i++)
      drive(1'b1, pick_op(), pick_op(), 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1);
    repeat (STAGES + 2) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("stream_drained", 64'(q.size()), 64'd0);

    for (int unsigned i = 0; i < 3; i++)
      drive(1'b1, 64'(i + 10), 64'd7, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    drive(1'b1, 64'd5, 64'd6, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    chk("midrst_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_ready", 64'(bus.in_ready), 64'd1);
    repeat (STAGES + 4) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

    issued = 0;
    guard = 0;
    while (issued < 10000 && guard < 60000) begin
      bus.in_valid = 1'($urandom_range(1));
      bus.in1 = pick_op();
      bus.in2 = pick_op();
      bus.cin = 1'($urandom_range(1));
      bus.sub = 1'($urandom_range(1));
      bus.out_ready = 1'($urandom_range(1));
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) issued++;
      @(posedge clk);
      #1;
      guard++;
    end
    chk("bp_issued", 64'(issued), 64'd10000);
    guard = 0;
    while (q.size() > 0 && guard < 100) begin
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      guard++;
    end
    chk("bp_drained", 64'(q.size()), 64'd0);

    guard = 0;
    while (sweep_done < 4 && guard < 1000) begin
      @(posedge clk);
      guard++;
    end
    chk("sweeps_done", 64'(sweep_done), 64'd4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int W = (g == 0) ? 8 : (g == 1) ? 16 : (g == 2) ? 64 : 32;
    localparam int S = (g == 0) ? 1 : (g == 1) ? 2  : (g == 2) ? 8  : 32;

    pipelined_adder_if #(.WIDTH(W)) sif ();
    pipelined_adder #(.WIDTH(W), .STAGES(S)) u_dut (.clk(clk), .rst(rst_sw), .bus(sif));

    logic [63:0] qs[$];
    logic        qc[$];
    logic        qo[$];
    int          qa[$];

    initial begin : p_drv
      logic [63:0] vals [4];
      logic [63:0] es;
      logic ec, eo, ci, sb;
      vals[0] = 64'd0;
      vals[1] = 64'd1;
      vals[2] = (W == 64) ? '1 : ((64'd1 << W) - 64'd1);
      vals[3] = 64'd1 << (W - 1);
      sif.in_valid = 1'b0;
      sif.in1 = '0;
      sif.in2 = '0;
      sif.cin = 1'b0;
      sif.sub = 1'b0;
      sif.out_ready = 1'b1;
      wait (rst_sw == 1'b0);
      @(posedge clk);
      #1;
      for (int unsigned i = 0; i < 4; i++)
        for (int unsigned j = 0; j < 4; j++)
          for (int unsigned s = 0; s < 2; s++) begin
            ci = 1'((i + j) % 2);
            sb = (s == 1);
            ref_op(W, vals[i], vals[j], ci, sb, es, ec, eo);
            sif.in_valid = 1'b1;
            sif.in1 = vals[i][W-1:0];
            sif.in2 = vals[j][W-1:0];
            sif.cin = ci;
            sif.sub = sb;
            qs.push_back(es);
            qc.push_back(ec);
            qo.push_back(eo);
            qa.push_back(cyc);
            @(posedge clk);
            #1;
          end
      sif.in_valid = 1'b0;
      repeat (S + 3) @(posedge clk);
      #1;
      chk($sformatf("sweep%0d_drained", g), 64'(qs.size()), 64'd0);
      sweep_done++;
    end

    always @(negedge clk) begin : p_chk
      logic ev;
      if (!rst_sw) begin
        ev = (qs.size() > 0) && (cyc == qa[0] + S);
        chk($sformatf("sweep%0d_valid", g), 64'(sif.out_valid), 64'(ev));
        if (ev) begin
          if (sif.out_valid) begin
            chk($sformatf("sweep%0d_sum", g), 64'(sif.sum), qs[0]);
            chk($sformatf("sweep%0d_cout", g), 64'(sif.cout), 64'(qc[0]));
            chk($sformatf("sweep%0d_ovf", g), 64'(sif.ovf), 64'(qo[0]));
          end
          void'(qs.pop_front());
          void'(qc.pop_front());
          void'(qo.pop_front());
          void'(qa.pop_front());
        end
      end
    end
  end
endmodule
